// File: rtl/sdram_arbiter.sv
`timescale 1ns/1ps
// Two-port round-robin arbiter in front of a single-request SDRAM controller.
// One access in flight at a time: grant, issue until busy, wait for busy to fall, ack.
module sdram_arbiter #(
  parameter int HADDR_WIDTH = 24,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [HADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]  p0_wdata,
  output logic                   p0_ack,
  output logic [DATA_WIDTH-1:0]  p0_rdata,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [HADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]  p1_wdata,
  output logic                   p1_ack,
  output logic [DATA_WIDTH-1:0]  p1_rdata,
  output logic [HADDR_WIDTH-1:0] ctl_haddr,
  output logic [DATA_WIDTH-1:0]  ctl_data_input,
  output logic                   ctl_rd_enable,
  output logic                   ctl_wr_enable,
  input  logic [DATA_WIDTH-1:0]  ctl_data_output,
  input  logic                   ctl_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic                   last_q, last_d;
  logic                   gnt_q, gnt_d;
  logic                   we_q, we_d;
  logic [HADDR_WIDTH-1:0] ctl_haddr_q, ctl_haddr_d;
  logic [DATA_WIDTH-1:0]  ctl_data_input_q, ctl_data_input_d;
  logic                   rd_en_q, rd_en_d;
  logic                   wr_en_q, wr_en_d;
  logic                   p0_ack_q, p0_ack_d;
  logic                   p1_ack_q, p1_ack_d;
  logic [DATA_WIDTH-1:0]  p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0]  p1_rdata_q, p1_rdata_d;
  logic                   pick_p1;
  logic                   sel_we;

  // last_q = 1 means port 1 was granted last, so port 0 wins the next tie
  assign pick_p1 = p1_req & (~p0_req | ~last_q);
  assign sel_we  = pick_p1 ? p1_we : p0_we;

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    gnt_d            = gnt_q;
    we_d             = we_q;
    ctl_haddr_d      = ctl_haddr_q;
    ctl_data_input_d = ctl_data_input_q;
    rd_en_d          = rd_en_q;
    wr_en_d          = wr_en_q;
    p0_ack_d         = 1'b0;
    p1_ack_d         = 1'b0;
    p0_rdata_d       = p0_rdata_q;
    p1_rdata_d       = p1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (p0_req | p1_req) begin
          state_d          = ST_ISSUE;
          gnt_d            = pick_p1;
          last_d           = pick_p1;
          we_d             = sel_we;
          ctl_haddr_d      = pick_p1 ? p1_addr : p0_addr;
          ctl_data_input_d = pick_p1 ? p1_wdata : p0_wdata;
          wr_en_d          = sel_we;
          rd_en_d          = ~sel_we;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (ctl_busy) begin
          state_d = ST_WAIT;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (!ctl_busy) begin
          state_d  = ST_DONE;
          p0_ack_d = ~gnt_q;
          p1_ack_d = gnt_q;
          // Read data is captured on the same edge that observes busy low
          if (!we_q) begin
            if (gnt_q) begin
              p1_rdata_d = ctl_data_output;
            end else begin
              p0_rdata_d = ctl_data_output;
            end
          end else begin
            p0_rdata_d = p0_rdata_q;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      last_q           <= 1'b1;
      gnt_q            <= 1'b0;
      we_q             <= 1'b0;
      ctl_haddr_q      <= {HADDR_WIDTH{1'b0}};
      ctl_data_input_q <= {DATA_WIDTH{1'b0}};
      rd_en_q          <= 1'b0;
      wr_en_q          <= 1'b0;
      p0_ack_q         <= 1'b0;
      p1_ack_q         <= 1'b0;
      p0_rdata_q       <= {DATA_WIDTH{1'b0}};
      p1_rdata_q       <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q          <= state_d;
      last_q           <= last_d;
      gnt_q            <= gnt_d;
      we_q             <= we_d;
      ctl_haddr_q      <= ctl_haddr_d;
      ctl_data_input_q <= ctl_data_input_d;
      rd_en_q          <= rd_en_d;
      wr_en_q          <= wr_en_d;
      p0_ack_q         <= p0_ack_d;
      p1_ack_q         <= p1_ack_d;
      p0_rdata_q       <= p0_rdata_d;
      p1_rdata_q       <= p1_rdata_d;
    end
  end

  assign p0_ack         = p0_ack_q;
  assign p1_ack         = p1_ack_q;
  assign p0_rdata       = p0_rdata_q;
  assign p1_rdata       = p1_rdata_q;
  assign ctl_haddr      = ctl_haddr_q;
  assign ctl_data_input = ctl_data_input_q;
  assign ctl_rd_enable  = rd_en_q;
  assign ctl_wr_enable  = wr_en_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
// Bench for sdram_arbiter: host agents, a controller model with memory, and a
// transaction-level monitor that predicts grants from the round-robin rule.
module tb_sdram_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] ctl_haddr;
  logic [DW-1:0] ctl_data_input;
  logic          ctl_rd_enable, ctl_wr_enable;
  logic [DW-1:0] ctl_data_output;
  logic          ctl_busy;

  sdram_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .ctl_haddr(ctl_haddr), .ctl_data_input(ctl_data_input),
    .ctl_rd_enable(ctl_rd_enable), .ctl_wr_enable(ctl_wr_enable),
    .ctl_data_output(ctl_data_output), .ctl_busy(ctl_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            defer;
    int            blen;
    logic [DW-1:0] exp_own;
    logic [DW-1:0] exp_other;
    int            exp_lat;
    int            exp_en;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  op_t           q0[$];
  op_t           q1[$];
  int            pushed = 0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] ctl_mem [logic [AW-1:0]];

  // ---------------- host agents (one process drives both ports) ----------------
  bit            h_busy [2];
  op_t           h_cur  [2];
  int            h_gap  [2];
  int            h_lat  [2];
  int            last_lat [2];
  logic [DW-1:0] exp_rd [2];
  logic          h_req  [2];
  int            done_cnt = 0;
  bit            rand_gaps = 1'b0;

  task automatic host_step(input int p);
    logic [DW-1:0] own, oth;
    logic          ackp, acko;
    op_t           nxt;
    own  = (p == 0) ? p0_rdata : p1_rdata;
    oth  = (p == 0) ? p1_rdata : p0_rdata;
    ackp = (p == 0) ? p0_ack : p1_ack;
    acko = (p == 0) ? p1_ack : p0_ack;
    if (!rst_n) begin
      h_busy[p] = 1'b0;
      h_req[p]  = 1'b0;
      h_gap[p]  = 0;
      exp_rd[p] = 16'h0000;
      return;
    end
    if (h_busy[p]) begin
      h_lat[p]++;
      if (ackp) begin
        check("ack_exclusive", 32'(acko), 32'd0);
        if (h_cur[p].we) ref_mem[h_cur[p].a] = h_cur[p].d;
        else exp_rd[p] = ref_mem.exists(h_cur[p].a) ? ref_mem[h_cur[p].a] : dflt(h_cur[p].a);
        check((p == 0) ? "p0_rdata" : "p1_rdata", 32'(own), 32'(exp_rd[p]));
        check("other_rdata_held", 32'(oth), 32'(exp_rd[1-p]));
        last_lat[p] = h_lat[p];
        h_busy[p]   = 1'b0;
        done_cnt++;
        h_gap[p] = (rand_gaps && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      end else if (h_lat[p] > 2000) begin
        check("ack_timeout", 32'(h_lat[p]), 32'd0);
        h_busy[p] = 1'b0;
      end
    end
    if (!h_busy[p]) begin
      if (h_gap[p] > 0) begin
        h_gap[p]--;
        h_req[p] = 1'b0;
      end else if ((p == 0 && q0.size() > 0) || (p == 1 && q1.size() > 0)) begin
        if (p == 0) nxt = q0.pop_front();
        else nxt = q1.pop_front();
        h_cur[p]  = nxt;
        h_busy[p] = 1'b1;
        h_lat[p]  = 0;
        h_req[p]  = 1'b1;
      end else begin
        h_req[p] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      h_busy[p] = 1'b0; h_gap[p] = 0; h_lat[p] = 0; last_lat[p] = 0;
      exp_rd[p] = 16'h0000; h_req[p] = 1'b0;
      h_cur[p]  = '{we: 1'b0, a: 24'h000000, d: 16'h0000};
    end
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 24'h000000; p0_wdata = 16'h0000;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 24'h000000; p1_wdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) host_step(p);
      p0_req = h_req[0]; p0_we = h_cur[0].we; p0_addr = h_cur[0].a; p0_wdata = h_cur[0].d;
      p1_req = h_req[1]; p1_we = h_cur[1].we; p1_addr = h_cur[1].a; p1_wdata = h_cur[1].d;
    end
  end

  // ---------------- SDRAM controller model ----------------
  int cfg_defer = 1;
  int cfg_blen  = 1;
  bit cfg_rand  = 1'b0;

  initial begin
    int m_mode, m_cnt, m_defer, m_blen;
    ctl_busy = 1'b0; ctl_data_output = 16'h0000;
    m_mode = 0; m_cnt = 0; m_defer = 1; m_blen = 1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ctl_busy = 1'b0; m_mode = 0; m_cnt = 0;
      end else if (m_mode == 0) begin
        if (ctl_rd_enable || ctl_wr_enable) begin
          if (m_cnt == 0) begin
            m_defer = cfg_rand ? int'($urandom_range(1, 4)) : cfg_defer;
            m_blen  = cfg_rand ? int'($urandom_range(1, 4)) : cfg_blen;
          end
          m_cnt++;
          if (m_cnt >= m_defer) begin
            ctl_busy = 1'b1; m_mode = 1; m_cnt = 1;
            if (ctl_wr_enable) ctl_mem[ctl_haddr] = ctl_data_input;
            else ctl_data_output = ctl_mem.exists(ctl_haddr) ? ctl_mem[ctl_haddr] : dflt(ctl_haddr);
          end
        end else begin
          m_cnt = 0;
        end
      end else begin
        if (m_cnt >= m_blen) begin
          ctl_busy = 1'b0; m_mode = 0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // ---------------- transaction monitor / grant reference ----------------
  bit            m_idle = 1'b1;
  logic          m_last = 1'b1;
  logic          m_pred = 1'b0;
  logic [AW-1:0] pred_a = 24'h000000;
  logic [DW-1:0] pred_d = 16'h0000;
  logic          pred_we = 1'b0;
  int            since = 0, en_cnt = 0, last_en = 0, cyc = 0;
  int            viol_dual_en = 0, viol_dual_ack = 0, viol_spur_ack = 0;
  int            viol_en_out = 0, viol_hold = 0, viol_type = 0, viol_lost = 0;
  logic          ack_log[$];
  int            ack_cyc[$];
  logic [AW-1:0] iss_log[$];

  initial begin
    logic en, prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      en = ctl_rd_enable | ctl_wr_enable;
      if (!rst_n) begin
        m_idle = 1'b1; m_last = 1'b1; prev_en = 1'b0;
      end else begin
        if (ctl_rd_enable && ctl_wr_enable) viol_dual_en++;
        if (p0_ack && p1_ack) viol_dual_ack++;
        if (p0_ack || p1_ack) begin
          if (en) viol_en_out++;
          if (m_idle) viol_spur_ack++;
          else begin
            check("grant_order", 32'(p1_ack), 32'(m_pred));
            if (ctl_haddr !== pred_a) viol_hold++;
            ack_log.push_back(p1_ack);
            ack_cyc.push_back(cyc);
            last_en = en_cnt;
            m_last  = p1_ack;
            m_idle  = 1'b1;
          end
        end else if (m_idle) begin
          if (en) viol_en_out++;
          if (p0_req || p1_req) begin
            m_pred  = (p0_req && p1_req) ? ~m_last : p1_req;
            pred_a  = m_pred ? p1_addr : p0_addr;
            pred_d  = m_pred ? p1_wdata : p0_wdata;
            pred_we = m_pred ? p1_we : p0_we;
            m_idle  = 1'b0; since = 0; en_cnt = 0;
          end
        end else begin
          since++;
          if (ctl_haddr !== pred_a) viol_hold++;
          if (pred_we && ctl_data_input !== pred_d) viol_hold++;
          if (since == 1 && !en) viol_lost++;
          if (en) begin
            en_cnt++;
            if (ctl_wr_enable !== pred_we) viol_type++;
            if (!prev_en) iss_log.push_back(ctl_haddr);
          end
        end
        prev_en = en;
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic wait_idle(input int bound, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = (q0.size() == 0) && (q1.size() == 0) && !h_busy[0] && !h_busy[1] &&
           (h_gap[0] == 0) && (h_gap[1] == 0) && m_idle;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic push(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o = '{we: we, a: a, d: d};
    if (p == 0) q0.push_back(o);
    else q1.push_back(o);
    pushed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- main test ----------------
  initial begin
    vec_t vt [6];
    int   n0;
    logic v;
    rst_n = 1'b0;
    vt[0] = '{0, 1'b1, 24'h000123, 16'hBEEF,  1, 2, 16'h0000, 16'h0000,  4,  1};
    vt[1] = '{1, 1'b0, 24'h000123, 16'h0000,  2, 1, 16'hBEEF, 16'h0000,  4,  2};
    vt[2] = '{0, 1'b0, 24'h000123, 16'h0000,  1, 1, 16'hBEEF, 16'hBEEF,  3,  1};
    vt[3] = '{1, 1'b1, 24'h000200, 16'h1234,  3, 3, 16'hBEEF, 16'hBEEF,  7,  3};
    vt[4] = '{0, 1'b0, 24'h000200, 16'h0000, 21, 2, 16'h1234, 16'hBEEF, 24, 21};
    vt[5] = '{1, 1'b0, 24'h000300, 16'h0000,  1, 1, 16'h595A, 16'h1234,  3,  1};

    repeat (3) @(negedge clk);
    check("rst_ctl_flags", 32'({ctl_rd_enable, ctl_wr_enable, p0_ack, p1_ack}), 32'd0);
    check("rst_haddr", 32'(ctl_haddr), 32'd0);
    check("rst_data_input", 32'(ctl_data_input), 32'd0);
    check("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    check("rst_p1_rdata", 32'(p1_rdata), 32'd0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cfg_defer = vt[i].defer;
      cfg_blen  = vt[i].blen;
      n0 = ack_log.size();
      push(vt[i].port, vt[i].we, vt[i].a, vt[i].d);
      wait_idle(300, "vec_idle");
      check("vec_ack_count", 32'(ack_log.size() - n0), 32'd1);
      v = (ack_log.size() > 0) ? ack_log[ack_log.size()-1] : 1'bx;
      check("vec_ack_port", 32'(v), 32'(vt[i].port));
      check("vec_own_rdata", 32'((vt[i].port == 0) ? p0_rdata : p1_rdata), 32'(vt[i].exp_own));
      check("vec_other_rdata", 32'((vt[i].port == 0) ? p1_rdata : p0_rdata), 32'(vt[i].exp_other));
      check("vec_latency", 32'(last_lat[vt[i].port]), 32'(vt[i].exp_lat));
      check("vec_enable_cycles", 32'(last_en), 32'(vt[i].exp_en));
    end

    // both ports held busy from reset: strict alternation starting with port 0
    do_reset();
    ack_log.delete();
    cfg_defer = 1; cfg_blen = 1;
    push(0, 1'b1, 24'h000400, 16'h1111);
    push(0, 1'b1, 24'h000401, 16'h2222);
    push(1, 1'b1, 24'h000500, 16'h3333);
    push(1, 1'b1, 24'h000501, 16'h4444);
    wait_idle(200, "tie_idle");
    check("tie_ack_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      v = (i < ack_log.size()) ? ack_log[i] : 1'bx;
      check("tie_order", 32'(v), 32'(i % 2));
    end

    // back-to-back on port 0 with a new address after the ack
    cfg_defer = 1; cfg_blen = 2;
    push(0, 1'b0, 24'h000123, 16'h0000);
    push(0, 1'b1, 24'h000124, 16'hCAFE);
    wait_idle(200, "b2b_idle");
    check("b2b_ctl_write", 32'(ctl_mem.exists(24'h000124) ? ctl_mem[24'h000124] : 16'hxxxx), 32'h0000CAFE);
    check("b2b_issue_addr", 32'((iss_log.size() > 0) ? iss_log[iss_log.size()-1] : 24'hxxxxxx), 32'h00000124);
    check("b2b_ack_gap", 32'((ack_cyc.size() > 1) ? ack_cyc[ack_cyc.size()-1] - ack_cyc[ack_cyc.size()-2] : 0), 32'd5);

    // reset while the controller is busy
    cfg_defer = 1; cfg_blen = 50;
    push(0, 1'b0, 24'h000200, 16'h0000);
    n0 = 0;
    for (int i = 0; i < 100 && n0 == 0; i++) begin
      @(negedge clk);
      if (ctl_busy) n0 = 1;
    end
    check("mid_busy_seen", 32'(n0), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_flags", 32'({ctl_rd_enable, ctl_wr_enable, p0_ack, p1_ack}), 32'd0);
    check("mid_rst_haddr", 32'(ctl_haddr), 32'd0);
    check("mid_rst_data_input", 32'(ctl_data_input), 32'd0);
    check("mid_rst_p0_rdata", 32'(p0_rdata), 32'd0);
    check("mid_rst_p1_rdata", 32'(p1_rdata), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    cfg_blen = 2;
    n0 = ack_log.size();
    push(1, 1'b0, 24'h000123, 16'h0000);
    wait_idle(200, "post_rst_idle");
    check("post_rst_ack_count", 32'(ack_log.size() - n0), 32'd1);
    check("post_rst_p1_rdata", 32'(p1_rdata), 32'h0000BEEF);

    // randomized traffic, disjoint address windows per port
    rand_gaps = 1'b1;
    cfg_rand  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      push(0, 1'($urandom_range(0, 1)), 24'h010000 | 24'($urandom_range(0, 15)), 16'($urandom));
      push(1, 1'($urandom_range(0, 1)), 24'h020000 | 24'($urandom_range(0, 15)), 16'($urandom));
    end
    wait_idle(8000, "rand_idle");

    check("done_count", 32'(done_cnt), 32'(pushed - 1));
    check("never_both_enables", 32'(viol_dual_en), 32'd0);
    check("never_both_acks", 32'(viol_dual_ack), 32'd0);
    check("no_spurious_ack", 32'(viol_spur_ack), 32'd0);
    check("enable_only_in_issue", 32'(viol_en_out), 32'd0);
    check("addr_data_stable", 32'(viol_hold), 32'd0);
    check("enable_type", 32'(viol_type), 32'd0);
    check("issue_follows_grant", 32'(viol_lost), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
